// File: rtl/ir_a2d_seq.sv
// rtl/ir_a2d_seq.sv - IR line-sensor A2D acquisition sequencer
module ir_a2d_seq #(
   parameter int          PERIOD     = 1048576,
   parameter int          SETTLE     = 4096,
   parameter logic [11:0] LINE_THRES = 12'h200
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic        IR_EN,
   output logic        wrt,
   output logic [15:0] cmd,
   input  logic        done,
   input  logic [15:0] rd_data,
   output logic [11:0] IR_R0,
   output logic [11:0] IR_R1,
   output logic [11:0] IR_R2,
   output logic [11:0] IR_R3,
   output logic [11:0] IR_L0,
   output logic [11:0] IR_L1,
   output logic [11:0] IR_L2,
   output logic [11:0] IR_L3,
   output logic        IR_vld,
   output logic        line_present
);

   localparam int TW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
   localparam int SW = (SETTLE > 2) ? $clog2(SETTLE) : 1;
   localparam logic [TW-1:0] TMR_MAX = TW'(PERIOD - 1);
   localparam logic [SW-1:0] STL_MAX = SW'(SETTLE - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_SETTLE,
      S_TX1,
      S_WAIT1,
      S_GAP,
      S_TX2,
      S_WAIT2,
      S_NEXT,
      S_DONE
   } state_t;

   state_t          state;
   state_t          nxt_state;
   logic            start;
   logic [TW-1:0]   tmr;
   logic [SW-1:0]   stl_cnt;
   logic [2:0]      chnl;
   logic [11:0]     ir_rd [8];
   logic            line_hit;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= nxt_state;
      end
   end

   // Next-state decode and state-derived outputs
   always_comb begin
      nxt_state = state;
      start     = 1'b0;
      IR_EN     = 1'b0;
      wrt       = 1'b0;
      IR_vld    = 1'b0;
      case (state)
         S_IDLE: begin
            if (tmr == TMR_MAX && en) begin
               nxt_state = S_SETTLE;
               start     = 1'b1;
            end
         end
         S_SETTLE: begin
            IR_EN = 1'b1;
            if (stl_cnt == STL_MAX) nxt_state = S_TX1;
         end
         S_TX1: begin
            IR_EN     = 1'b1;
            wrt       = 1'b1;
            nxt_state = S_WAIT1;
         end
         S_WAIT1: begin
            IR_EN = 1'b1;
            if (done) nxt_state = S_GAP;
         end
         S_GAP: begin
            IR_EN     = 1'b1;
            nxt_state = S_TX2;
         end
         S_TX2: begin
            IR_EN     = 1'b1;
            wrt       = 1'b1;
            nxt_state = S_WAIT2;
         end
         S_WAIT2: begin
            IR_EN = 1'b1;
            if (done) nxt_state = S_NEXT;
         end
         S_NEXT: begin
            IR_EN     = 1'b1;
            nxt_state = (chnl == 3'd7) ? S_DONE : S_TX1;
         end
         S_DONE: begin
            IR_vld    = 1'b1;
            nxt_state = S_IDLE;
         end
         default: nxt_state = S_IDLE;
      endcase
   end

   // Period timer: free-runs across the round so starts stay PERIOD apart
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr <= '0;
      end else if (start) begin
         tmr <= '0;
      end else if (tmr != TMR_MAX) begin
         tmr <= tmr + TW'(1);
      end
   end

   // Emitter settle counter, only counts while in SETTLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stl_cnt <= '0;
      end else if (state == S_SETTLE) begin
         stl_cnt <= stl_cnt + SW'(1);
      end else begin
         stl_cnt <= '0;
      end
   end

   // Channel pointer: restarts at 0 on each round, advances after each pair
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chnl <= 3'd0;
      end else if (start) begin
         chnl <= 3'd0;
      end else if (state == S_NEXT && chnl != 3'd7) begin
         chnl <= chnl + 3'd1;
      end
   end

   assign cmd = {2'b00, chnl, 11'h000};

   // Capture the second transaction's data; the first returns the stale conversion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) ir_rd[i] <= 12'h000;
      end else if (state == S_WAIT2 && done) begin
         ir_rd[chnl] <= rd_data[11:0];
      end
   end

   // Any reading strictly above threshold (unsigned)
   always_comb begin
      line_hit = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (ir_rd[i] > LINE_THRES) line_hit = 1'b1;
      end
   end

   // Line flag refreshed on the way into DONE so it is valid with IR_vld
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_present <= 1'b0;
      end else if (state == S_NEXT && chnl == 3'd7) begin
         line_present <= line_hit;
      end
   end

   assign IR_R0 = ir_rd[0];
   assign IR_R1 = ir_rd[1];
   assign IR_R2 = ir_rd[2];
   assign IR_R3 = ir_rd[3];
   assign IR_L0 = ir_rd[4];
   assign IR_L1 = ir_rd[5];
   assign IR_L2 = ir_rd[6];
   assign IR_L3 = ir_rd[7];

endmodule
